// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants and types shared across the single-cycle core.
//   CPU_DATA_W     : instruction / data word width
//   CPU_ADDR_W     : instruction PC width, in words
//   CPU_IMEM_DEPTH : implemented instruction memory words
//   fetch_state_e  : instruction fetch memory mode (program load vs. run)
package cpu_pkg;

  localparam int CPU_DATA_W     = 32;
  localparam int CPU_ADDR_W     = 10;
  localparam int CPU_IMEM_DEPTH = 1024;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/imem_ram.sv
// imem_ram -- instruction memory array, one write port and one synchronous
// read port. The read register only updates when re is high, so a read
// result stays put while the consumer stalls. Contents are never reset.
//   clk   : clock, rising edge
//   we    : write enable; wdata is stored at waddr
//   waddr : write word address (must be < DEPTH when we is high)
//   wdata : write data
//   re    : read enable; mem[raddr] appears on rdata after the edge
//   raddr : read word address (must be < DEPTH when re is high)
//   rdata : registered read data
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;

  // Callers guarantee in-range addresses, so only the low bits select a word.
  assign widx = waddr[IDX_W-1:0];
  assign ridx = raddr[IDX_W-1:0];

  if (ADDR_W > IDX_W) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^{waddr[ADDR_W-1:IDX_W], raddr[ADDR_W-1:IDX_W]};
  end

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem -- instruction memory with a sequential program-load mode
// and a one-cycle-latency valid/ready fetch port.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   load_valid/data/last  : program words written to consecutive addresses
//   loaded                : high once the program is loaded (RUN)
//   req_valid/pc/ready    : fetch request handshake
//   rsp_valid/instr/pc/err/ready : fetch response handshake; err flags an
//                           out-of-range PC and forces instr to zero
//   flush                 : drops the pending response and blocks acceptance
module instr_fetch_mem
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = CPU_IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              loaded,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic              rsp_err,
  input  logic              rsp_ready,
  input  logic              flush
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] load_ptr;
  logic              load_we;
  logic              accept;
  logic              pc_ok;

  logic              vld_p1;
  logic              err_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [DATA_W-1:0] rdata_p1;

  // ---- request stage (p0): FSM, load pointer, request acceptance ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_we   = 1'b0;
    case (state)
      ST_LOAD: begin
        if (load_valid) begin
          load_we = 1'b1;
          // Filling the last implemented word ends the load even without load_last.
          if (load_last || (load_ptr == LAST_PTR)) state_nxt = ST_RUN;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       load_ptr <= '0;
    else if (load_we) load_ptr <= load_ptr + 1'b1;
  end

  assign loaded    = (state == ST_RUN);
  assign req_ready = loaded && (!vld_p1 || rsp_ready) && !flush;
  assign accept    = req_valid && req_ready;
  assign pc_ok     = ({1'b0, req_pc} < DEPTH_X);

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (load_we),
    .waddr (load_ptr),
    .wdata (load_data),
    .re    (accept && pc_ok),
    .raddr (req_pc),
    .rdata (rdata_p1)
  );

  // ---- response stage (p1): response register, flush has top priority ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      pc_p1  <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      err_p1 <= !pc_ok;
      pc_p1  <= req_pc;
    end else if (rsp_ready) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end
  end

  // RAM data is not reset; gating on valid gives a zero instr out of reset
  // and for out-of-range fetches that never touched the array.
  assign rsp_valid = vld_p1;
  assign rsp_err   = err_p1;
  assign rsp_pc    = pc_p1;
  assign rsp_instr = (vld_p1 && !err_p1) ? rdata_p1 : '0;

endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          loaded;
  logic          req_valid;
  logic [AW-1:0] req_pc;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_instr;
  logic [AW-1:0] rsp_pc;
  logic          rsp_err;
  logic          rsp_ready;
  logic          flush;

  instr_fetch_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .loaded(loaded),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_pc(rsp_pc),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_loaded;
  int            mdl_ptr;
  bit            mdl_vld;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: program-load bookkeeping, handshake rules and the
  // expected response for every accepted request. Evaluated mid-cycle, it
  // checks the current outputs and then predicts the next edge.
  always @(negedge clk) begin
    bit   exp_ready;
    bit   acc;
    exp_t e;
    if (!rst_n) begin
      mdl_loaded = 0;
      mdl_ptr    = 0;
      mdl_vld    = 0;
      exp_q.delete();
    end else begin
      chk("loaded", loaded, mdl_loaded);
      chk("rsp_valid", rsp_valid, mdl_vld);
      exp_ready = mdl_loaded && (!mdl_vld || rsp_ready) && !flush;
      chk("req_ready", req_ready, exp_ready);
      if (!rsp_valid) chk("err_when_idle", rsp_err, 0);
      acc = req_valid && exp_ready;
      if (acc) begin
        e.pc    = req_pc;
        e.err   = (int'(req_pc) >= DEPTH);
        e.instr = e.err ? '0 : mdl_mem[int'(req_pc)];
        exp_q.push_back(e);
      end
      if (!mdl_loaded && load_valid) begin
        mdl_mem[mdl_ptr] = load_data;
        if (load_last || mdl_ptr == DEPTH - 1) mdl_loaded = 1;
        mdl_ptr++;
      end
      if (flush)          mdl_vld = 0;
      else if (acc)       mdl_vld = 1;
      else if (rsp_ready) mdl_vld = 0;
    end
  end

  // Monitor: every presented response is compared with the oldest expected
  // one; it is retired when consumed or flushed.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got pc %0d with no request outstanding at %0t", rsp_pc, $time);
      end else begin
        e = exp_q[0];
        chk("rsp_instr", rsp_instr, e.instr);
        chk("rsp_pc", rsp_pc, e.pc);
        chk("rsp_err", rsp_err, e.err);
        if (rsp_ready || flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 0; load_data = '0; load_last = 0;
    req_valid = 0; req_pc = '0; rsp_ready = 1; flush = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_loaded", loaded, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_instr", rsp_instr, 0);
    chk("rst_rsp_pc", rsp_pc, 0);
    chk("rst_req_ready", req_ready, 0);
    idle_inputs();
    cyc();
    cyc();
    rst_n = 1;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    load_valid = 1; load_data = d; load_last = last;
    cyc();
    load_valid = 0; load_last = 0;
  endtask

  task automatic fetch(input int pc);
    req_valid = 1; req_pc = AW'(pc);
    cyc();
    req_valid = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1;
    #2;
    do_reset();

    // Fetch attempts while still loading are refused.
    req_valid = 1; req_pc = 0;
    cyc(); cyc();
    req_valid = 0;

    // Three-word program, then back-to-back fetches.
    load_word(10, 0);
    load_word(20, 0);
    load_word(30, 1);
    cyc();
    for (int i = 0; i < 3; i++) fetch(i);
    cyc();

    // Stall the consumer for three cycles with a request waiting.
    rsp_ready = 0;
    fetch(1);
    req_valid = 1; req_pc = 2;
    cyc(); cyc(); cyc();
    req_valid = 0; rsp_ready = 1;
    cyc(); cyc();

    // Flush arrives with the response and a competing request.
    fetch(2);
    flush = 1; req_valid = 1; req_pc = 0;
    cyc();
    flush = 0; req_valid = 0;
    cyc(); cyc();

    // Reset in the middle of a load, reload, reset in the middle of a fetch.
    do_reset();
    load_word(32'h111, 0);
    load_word(32'h222, 0);
    do_reset();
    load_word(32'hA1, 0);
    load_word(32'hB2, 0);
    load_word(32'hC3, 1);
    rsp_ready = 0;
    fetch(1);
    do_reset();
    load_word(32'hD4, 0);
    load_word(32'hE5, 0);
    load_word(32'hF6, 1);
    for (int i = 0; i < 3; i++) fetch(i);
    cyc();

    // Full-depth load with no load_last; extra load words must be ignored.
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word($urandom, 0);
    load_word(32'hDEAD_BEEF, 0);
    load_word(32'hCAFE_F00D, 1);
    fetch(DEPTH);
    for (int i = 0; i < DEPTH; i++) fetch(i);
    fetch(31);
    cyc(); cyc();

    // Randomised traffic with stalls, flushes and out-of-range PCs.
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(3) != 0);
      req_pc     = ($urandom_range(7) == 0) ? AW'(DEPTH + $urandom_range(DEPTH - 1))
                                            : AW'($urandom_range(DEPTH - 1));
      rsp_ready  = ($urandom_range(3) != 0);
      flush      = ($urandom_range(9) == 0);
      load_valid = ($urandom_range(7) == 0);
      load_data  = $urandom;
      cyc();
    end
    idle_inputs();
    cyc(); cyc(); cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 10, PC width in words.
REQ-003 SHALL have parameter DEPTH, default 1024, implemented words (DEPTH <= 2**ADDR_W).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports load_valid  input  1 and load_data  input  DATA_W: sequential program-load word.
REQ-007 SHALL have port load_last  input  1  marks final load word.
REQ-008 SHALL have port loaded  output  1  high in RUN state.
REQ-009 SHALL have ports req_valid  input  1, req_pc  input  ADDR_W, req_ready  output  1: fetch request.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_instr  output  DATA_W, rsp_pc  output  ADDR_W, rsp_err  output  1, rsp_ready  input  1: fetch response.
REQ-011 SHALL have port flush  input  1  discards pending response (branch redirect).

Function
REQ-012 SHALL implement a two-state FSM: LOAD (after reset) and RUN.
REQ-013 In LOAD, each cycle with load_valid SHALL write load_data to mem[load_ptr] and increment load_ptr.
REQ-014 LOAD->RUN SHALL occur on the edge accepting a word with load_last, or the word written at load_ptr = DEPTH-1, whichever first.
REQ-015 load_valid in RUN SHALL be ignored; RUN SHALL persist until reset.
REQ-016 req_ready SHALL equal (state==RUN) && (!rsp_valid || rsp_ready) && !flush.
REQ-017 Request accepted at edge N (req_valid && req_ready) SHALL present rsp_valid=1 with rsp_instr=mem[req_pc], rsp_pc=req_pc after edge N: one-cycle latency.
REQ-018 Back-to-back accepted requests SHALL yield one response per cycle with no bubble while rsp_ready=1.
REQ-019 With rsp_valid=1 and rsp_ready=0, rsp_instr, rsp_pc, rsp_err SHALL hold stable.
REQ-020 Response consumed (rsp_ready=1) with no new acceptance SHALL clear rsp_valid next edge.
REQ-021 req_pc >= DEPTH SHALL return rsp_err=1, rsp_instr=0; no memory access.
REQ-022 flush=1 at an edge SHALL clear rsp_valid and accept no request that edge; flush takes priority over req_valid and rsp_ready.
REQ-023 rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-024 Memory contents SHALL be retained across RUN; unwritten words read 0 only if simulation-initialised, otherwise undefined.

Reset
REQ-025 rst_n low SHALL immediately force state=LOAD, load_ptr=0, loaded=0, rsp_valid=0, rsp_err=0, rsp_instr=0, rsp_pc=0; memory array SHALL NOT be reset.
REQ-026 Reset asserted mid-load or mid-fetch SHALL abort the operation; after release a full reload is required.

Structure
REQ-027 State encodings and default widths SHALL live in a shared package (cpu_pkg) alongside other single-cycle core constants.
REQ-028 Memory array SHALL be a sub-module imem_ram (1 write port, 1 synchronous read port, parametrised DATA_W/ADDR_W/DEPTH); FSM, pointer, and response register in instr_fetch_mem.

Verification
REQ-029 Load words 10,20,30 with load_last on 30 -> loaded=1 on following cycle; fetch pc 0,1,2 back-to-back -> rsp_instr 10,20,30 on consecutive cycles.
REQ-030 Hold rsp_ready=0 three cycles after fetch pc=1 -> rsp_instr=20, rsp_pc=1 stable, req_ready=0 throughout.
REQ-031 DEPTH=16, load 16 words without load_last -> RUN after 16th word; extra load_valid ignored; fetch pc=16 -> rsp_err=1, rsp_instr=0.
REQ-032 Fetch pc=2 then flush same cycle as response -> rsp_valid=0 next cycle, request presented with flush not accepted.
REQ-033 Assert rst_n=0 after 2 of 3 load words and again during fetch -> outputs zero immediately, loaded=0, reload of 3 words then fetch returns new data.
REQ-034 Fetch during LOAD -> req_ready=0, no rsp_valid until loaded=1.
